// File: rtl/nios2_mult_pkg.sv
// -----------------------------------------------------------------------------
// nios2_mult_pkg
// Shared types and helpers for the Nios II pipelined multiplier cell.
//   mult_op_t   : operation encoding carried down the pipe
//   OP_W        : width of the op field
//   PIPE_DEPTH  : accept-to-result latency in cycles
//   is_high     : op returns the upper product half
//   a_is_signed : operand A is treated as two's complement
//   b_is_signed : operand B is treated as two's complement
// -----------------------------------------------------------------------------
package nios2_mult_pkg;

  localparam int OP_W       = 2;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [OP_W-1:0] {
    MUL    = 2'b00,  // low half, sign-independent
    MULXSS = 2'b01,  // high half, signed x signed
    MULXSU = 2'b10,  // high half, signed a x unsigned b
    MULXUU = 2'b11   // high half, unsigned x unsigned
  } mult_op_t;

  function automatic logic is_high(input mult_op_t op);
    return (op != MUL);
  endfunction

  function automatic logic a_is_signed(input mult_op_t op);
    return (op == MULXSS) || (op == MULXSU);
  endfunction

  function automatic logic b_is_signed(input mult_op_t op);
    return (op == MULXSS);
  endfunction

endpackage

// File: rtl/nios2_mult_slice.sv
// -----------------------------------------------------------------------------
// nios2_mult_slice
// Registered SLICE_W x SLICE_W unsigned multiplier; one per DSP multiplier.
//   clk : clock
//   en  : load enable (pipeline advance)
//   a,b : unsigned operand slices
//   p   : registered 2*SLICE_W product
// -----------------------------------------------------------------------------
module nios2_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [SLICE_W-1:0]     a,
  input  logic [SLICE_W-1:0]     b,
  output logic [2*SLICE_W-1:0]   p
);

  logic [2*SLICE_W-1:0] p_d;
  logic [2*SLICE_W-1:0] p_q;

  always_comb p_d = a * b;

  // NOTE: pure datapath register with no reset; its contents only matter when
  // the matching valid bit (which is reset) says so, and that keeps it DSP-mappable.
  always_ff @(posedge clk) begin
    if (en) p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nios2_mult_pipe_cell.sv
// -----------------------------------------------------------------------------
// nios2_mult_pipe_cell
// Three-stage pipelined integer multiplier for the Nios II execute/memory path.
//   S1: operand registers plus (WIDTH/SLICE_W)^2 registered slice products
//   S2: shift-sum into a 2*WIDTH product with signed-operand correction
//   S3: low/high half select into the output register
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush                : kill every in-flight operation
//   in_valid/in_ready    : input handshake; in_op, in_a, in_b, in_tag, acc_en
//   out_valid/out_ready  : output handshake; out_result, out_tag
// Build option:
//   MULT_CELL_ACC_EN     : adds a MUL accumulator (out = P[W-1:0] + acc) driven
//                          by acc_en; without it acc_en is ignored.
// -----------------------------------------------------------------------------
module nios2_mult_pipe_cell
  import nios2_mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NS = WIDTH / SLICE_W;  // slices per operand
  localparam int NP = NS * NS;          // partial products

  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("nios2_mult_pipe_cell: WIDTH must be a multiple of SLICE_W");
  end

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipe freezes while a result waits on the consumer.
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;
  logic out_valid_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage valid bits
  // ---------------------------------------------------------------------------
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic out_valid_d;

  // NOTE: every variable driven here gets its hold value first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      s1_valid_d  = accept;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: operands and slice products
  // ---------------------------------------------------------------------------
  mult_op_t           s1_op_d, s1_op_q;
  logic [WIDTH-1:0]   s1_a_d, s1_a_q;
  logic [WIDTH-1:0]   s1_b_d, s1_b_q;
  logic [TAG_W-1:0]   s1_tag_d, s1_tag_q;
  logic [2*SLICE_W-1:0] pp [NP];

  always_comb begin
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_tag_d = s1_tag_q;
    if (!stall) begin
      s1_op_d  = mult_op_t'(in_op);
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_tag_d = in_tag;
    end
  end

  for (genvar i = 0; i < NS; i++) begin : g_a_slice
    for (genvar j = 0; j < NS; j++) begin : g_b_slice
      nios2_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
        .clk (clk),
        .en  (~stall),
        .a   (in_a[i*SLICE_W +: SLICE_W]),
        .b   (in_b[j*SLICE_W +: SLICE_W]),
        .p   (pp[i*NS + j])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // S2: shift-sum of unsigned partial products, then sign correction
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] raw_sum;
  logic [2*WIDTH-1:0] s2_prod_d, s2_prod_q;
  mult_op_t           s2_op_d, s2_op_q;
  logic [TAG_W-1:0]   s2_tag_d, s2_tag_q;

  always_comb begin
    logic [2*WIDTH-1:0] term;
    raw_sum = '0;
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) begin
        term                  = '0;
        term[2*SLICE_W-1:0]   = pp[i*NS + j];
        raw_sum               = raw_sum + (term << (SLICE_W * (i + j)));
      end
    end
  end

  always_comb begin
    s2_prod_d = s2_prod_q;
    s2_op_d   = s2_op_q;
    s2_tag_d  = s2_tag_q;
    if (!stall) begin
      // A negative signed operand x is read as x + 2^W by the unsigned array,
      // so subtract the other operand shifted up by W to undo it (mod 2^2W).
      s2_prod_d = raw_sum;
      if (a_is_signed(s1_op_q) && s1_a_q[WIDTH-1])
        s2_prod_d = s2_prod_d - {s1_b_q, {WIDTH{1'b0}}};
      if (b_is_signed(s1_op_q) && s1_b_q[WIDTH-1])
        s2_prod_d = s2_prod_d - {s1_a_q, {WIDTH{1'b0}}};
      s2_op_d  = s1_op_q;
      s2_tag_d = s1_tag_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: half select (and optional accumulate) into the output register
  // ---------------------------------------------------------------------------
  logic               s3_load;
  logic [WIDTH-1:0]   res_sel;
  logic [WIDTH-1:0]   out_result_d, out_result_q;
  logic [TAG_W-1:0]   out_tag_d, out_tag_q;

  assign s3_load = s2_valid_q & ~stall & ~flush;

`ifdef MULT_CELL_ACC_EN
  logic               s1_acc_d, s1_acc_q;
  logic               s2_acc_d, s2_acc_q;
  logic [WIDTH-1:0]   acc_d, acc_q;

  always_comb begin
    s1_acc_d = s1_acc_q;
    s2_acc_d = s2_acc_q;
    if (!stall) begin
      s1_acc_d = acc_en;
      s2_acc_d = s1_acc_q;
    end
  end

  always_comb begin
    res_sel = is_high(s2_op_q) ? s2_prod_q[2*WIDTH-1:WIDTH] : s2_prod_q[WIDTH-1:0];
    acc_d   = acc_q;
    if (s2_op_q == MUL && s2_acc_q) begin
      res_sel = s2_prod_q[WIDTH-1:0] + acc_q;
      if (s3_load) acc_d = res_sel;
    end
  end

  // Accumulator survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  always_ff @(posedge clk) begin
    s1_acc_q <= s1_acc_d;
    s2_acc_q <= s2_acc_d;
  end
`else
  logic unused_acc_en;
  assign unused_acc_en = acc_en;

  always_comb begin
    res_sel = is_high(s2_op_q) ? s2_prod_q[2*WIDTH-1:WIDTH] : s2_prod_q[WIDTH-1:0];
  end
`endif

  always_comb begin
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (s3_load) begin
      out_result_d = res_sel;
      out_tag_d    = s2_tag_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_op_q   <= s1_op_d;
    s1_a_q    <= s1_a_d;
    s1_b_q    <= s1_b_d;
    s1_tag_q  <= s1_tag_d;
    s2_prod_q <= s2_prod_d;
    s2_op_q   <= s2_op_d;
    s2_tag_q  <= s2_tag_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_nios2_mult_pipe_cell.sv
// -----------------------------------------------------------------------------
// tb_nios2_mult_pipe_cell
// Self-checking bench for nios2_mult_pipe_cell (WIDTH=32, SLICE_W=16, TAG_W=5).
// Expected results come from a wide signed-arithmetic reference model and a
// FIFO scoreboard; directed cases use literal values. Honors MULT_CELL_ACC_EN.
// -----------------------------------------------------------------------------
module tb_nios2_mult_pipe_cell;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'd0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          acc_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  nios2_mult_pipe_cell #(.WIDTH(W), .SLICE_W(16), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .acc_en     (acc_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sign- or zero-extend each operand and multiply exactly.
  function automatic logic [W-1:0] model_mul(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{34{a[W-1]}}, a} : {34'b0, a};
    eb = (op == 2'd1)               ? {{34{b[W-1]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  m_acc = '0;

  // Scoreboard: sampled on the falling edge, i.e. what the next rising edge commits.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", out_result, e.res);
        check("sb_tag", out_tag, e.tag);
      end
      n_done++;
    end
    if (reset || flush) begin
      exp_q.delete();
      if (reset) m_acc = '0;
    end else if (in_valid && in_ready) begin
      exp_t e;
      e.tag = in_tag;
      e.res = model_mul(in_op, in_a, in_b);
`ifdef MULT_CELL_ACC_EN
      if (in_op == 2'd0 && acc_en) begin
        e.res = e.res + m_acc;
        m_acc = e.res;
      end
`endif
      exp_q.push_back(e);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one op and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag, input logic acc);
    logic ok;
    int   waited;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    acc_en   = acc;
    ok       = 1'b0;
    waited   = 0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    acc_en   = 1'b0;
  endtask

  // Single op on an empty pipe: check latency and a literal expected result.
  task automatic run_one(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag, input logic acc,
                         input logic [W-1:0] exp);
    int lat;
    send(op, a, b, tag, acc);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check(name, out_result, exp);
    check({name, "_tag"}, out_tag, tag);
  endtask

  task automatic wait_done(input int target, input string name);
    int t;
    t = 0;
    while (n_done < target && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, n_done, target);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int base;
    logic [W-1:0] a0, b0;

    // ---- reset state ----
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    idle(1);

    // ---- directed products ----
    run_one("mul_low",  2'd0, 32'h0001_0000, 32'h0001_0000, 5'd1, 1'b0, 32'h0000_0000);
    run_one("mulxuu_1", 2'd3, 32'h0001_0000, 32'h0001_0000, 5'd2, 1'b0, 32'h0000_0001);
    run_one("mulxss_m1",2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 32'h0000_0000);
    run_one("mulxsu_m1",2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, 32'hFFFF_FFFF);
    run_one("mulxuu_m1",2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 32'hFFFF_FFFE);
    run_one("mulxss_mn",2'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, 32'h4000_0000);
    idle(2);

    // ---- back-pressure: 4 ops, consumer stalls 5 cycles on first result ----
    base      = n_done;
    a0        = $urandom;
    b0        = $urandom;
    out_ready = 1'b0;
    fork
      begin
        send(2'd0, a0, b0, 5'd10, 1'b0);
        send(2'd3, $urandom, $urandom, 5'd11, 1'b0);
        send(2'd1, $urandom, $urandom, 5'd12, 1'b0);
        send(2'd2, $urandom, $urandom, 5'd13, 1'b0);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
          @(posedge clk);
          #1;
          t++;
        end
        check("bp_first_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          check("bp_in_ready", in_ready, 0);
          check("bp_hold_tag", out_tag, 10);
          check("bp_hold_result", out_result, model_mul(2'd0, a0, b0));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_done(base + 4, "bp_all_done");
    idle(2);

    // ---- flush with 3 ops in flight (also while stalled) ----
    base      = n_done;
    out_ready = 1'b0;
    send(2'd0, 32'd3, 32'd5, 5'd20, 1'b0);
    send(2'd0, 32'd7, 32'd5, 5'd21, 1'b0);
    send(2'd0, 32'd9, 32'd5, 5'd22, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        if (out_valid) seen++;
        @(posedge clk);
        #1;
      end
      check("flush_no_result", seen, 0);
    end
    check("flush_no_done", n_done, base);
    run_one("post_flush", 2'd0, 32'd7, 32'd9, 5'd23, 1'b0, 32'd63);
    idle(2);

    // ---- reset with ops in flight ----
    out_ready = 1'b0;
    send(2'd0, 32'h1234, 32'h10, 5'd1, 1'b0);
    send(2'd0, 32'h55, 32'h3, 5'd2, 1'b0);
    send(2'd0, 32'h77, 32'h2, 5'd3, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_tag", out_tag, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    idle(1);

    // ---- accumulator (or its absence) ----
`ifdef MULT_CELL_ACC_EN
    run_one("acc_12",  2'd0, 32'd3, 32'd4, 5'd7, 1'b1, 32'd12);
    run_one("acc_42",  2'd0, 32'd5, 32'd6, 5'd8, 1'b1, 32'd42);
    run_one("acc_off", 2'd0, 32'd2, 32'd2, 5'd9, 1'b0, 32'd4);
    run_one("acc_hi_ignored", 2'd3, 32'd3, 32'd4, 5'd9, 1'b1, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    run_one("acc_after_rst", 2'd0, 32'd1, 32'd1, 5'd10, 1'b1, 32'd1);
`else
    run_one("noacc_12", 2'd0, 32'd3, 32'd4, 5'd7, 1'b1, 32'd12);
    run_one("noacc_30", 2'd0, 32'd5, 32'd6, 5'd8, 1'b1, 32'd30);
`endif
    idle(2);

    // ---- randomized traffic with random back-pressure ----
    base = n_done;
    begin
      logic took;
      took = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if (!in_valid || took) begin
          in_valid = ($urandom_range(0, 9) < 7);
          in_op    = 2'($urandom_range(0, 3));
          in_a     = rand_operand();
          in_b     = rand_operand();
          in_tag   = TW'($urandom);
          acc_en   = 1'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
      end
      in_valid  = 1'b0;
      acc_en    = 1'b0;
      out_ready = 1'b1;
    end
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
        idle(1);
        t++;
      end
      check("rand_drained", exp_q.size(), 0);
    end
    check("rand_progress", (n_done - base) > 100, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
